// File: rtl/vslc_timer_pkg.sv
// Shared constants for the VSLC timer bank: modes, config selectors, reset defaults, channel states.
package vslc_timer_pkg;

  localparam logic [1:0] MODE_CYCLE   = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_DELAY   = 2'd2;

  localparam logic [1:0] SEL_PERIOD_A = 2'd0;
  localparam logic [1:0] SEL_PERIOD_B = 2'd1;
  localparam logic [1:0] SEL_DIV      = 2'd2;
  localparam logic [1:0] SEL_MODE     = 2'd3;

  localparam int PERIOD_A_RST = 1;
  localparam int PERIOD_B_RST = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PHASE_A,
    ST_PHASE_B,
    ST_HOLD
  } tmr_state_e;

endpackage

// File: rtl/vslc_timer_channel.sv
// One timer channel: config registers, power-of-two prescaler, phase counter and mode FSM.
module vslc_timer_channel
  import vslc_timer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16,
  parameter int DIV_WIDTH     = 4,
  parameter int RETRIGGER     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cfg_we,
  input  logic [1:0]               i_cfg_sel,
  input  logic [COUNTER_WIDTH-1:0] i_cfg_data,
  input  logic                     i_en_set,
  input  logic                     i_en_clr,
  output logic                     o_out,
  output logic                     o_en,
  output logic                     o_done
);
  // Prescaler must hold 2^div-1 for the largest div.
  localparam int PW = (1 << DIV_WIDTH) - 1;

  tmr_state_e               r_state, w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_period_a, r_period_b;
  logic [DIV_WIDTH-1:0]     r_div;
  logic [1:0]               r_mode;
  logic [PW-1:0]            r_pre, w_pre_nxt, w_mask;
  logic [COUNTER_WIDTH-1:0] r_cnt, w_cnt_nxt, w_per;
  logic                     r_out, w_out_nxt, r_done, w_done_nxt;
  logic                     w_running, w_start, w_tick;

  assign w_running = (r_state != ST_IDLE);
  assign w_start   = i_en_set && (!w_running || (RETRIGGER != 0));
  assign w_mask    = ~({PW{1'b1}} << r_div);
  assign w_tick    = (r_pre == w_mask);
  assign w_per     = (r_state == ST_PHASE_B) ? r_period_b : r_period_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_out   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pre   <= w_pre_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pre_nxt   = r_pre;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    if (i_en_clr) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_pre_nxt   = '0;
      w_out_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ST_PHASE_A;
      w_cnt_nxt   = '0;
      w_pre_nxt   = '0;
      w_out_nxt   = (r_mode != MODE_DELAY);
    end else if (w_running) begin
      w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
      // HOLD freezes the count; only live phases evaluate the >= compare.
      if (w_tick && r_state != ST_HOLD) begin
        if (r_cnt >= w_per) begin
          w_cnt_nxt = '0;
          case (r_state)
            ST_PHASE_A: begin
              if (r_mode == MODE_DELAY) begin
                w_state_nxt = ST_HOLD;
                w_out_nxt   = 1'b1;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_PHASE_B;
                w_out_nxt   = 1'b0;
              end
            end
            ST_PHASE_B: begin
              if (r_mode == MODE_ONESHOT) begin
                w_state_nxt = ST_IDLE;
                w_out_nxt   = 1'b0;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_PHASE_A;
                w_out_nxt   = 1'b1;
              end
            end
            default: w_state_nxt = r_state;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + COUNTER_WIDTH'(1);
        end
      end
    end
    if (i_cfg_we && i_cfg_sel == SEL_DIV) w_pre_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_period_a <= COUNTER_WIDTH'(PERIOD_A_RST);
      r_period_b <= COUNTER_WIDTH'(PERIOD_B_RST);
      r_div      <= '0;
      r_mode     <= MODE_CYCLE;
    end else if (i_cfg_we) begin
      case (i_cfg_sel)
        SEL_PERIOD_A: r_period_a <= i_cfg_data;
        SEL_PERIOD_B: r_period_b <= i_cfg_data;
        SEL_DIV:      r_div      <= i_cfg_data[DIV_WIDTH-1:0];
        default:      r_mode     <= i_cfg_data[1:0];
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_en   = w_running;
  assign o_done = r_done;

endmodule

// File: rtl/vslc_timer_bank.sv
// Bank of NUM_TIMERS independent VSLC timers sharing one config write port.
module vslc_timer_bank
  import vslc_timer_pkg::*;
#(
  parameter int NUM_TIMERS    = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int DIV_WIDTH     = 4,
  parameter int RETRIGGER     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_chan,
  input  logic [1:0]               cfg_sel,
  input  logic [COUNTER_WIDTH-1:0] cfg_data,
  input  logic [NUM_TIMERS-1:0]    en_set,
  input  logic [NUM_TIMERS-1:0]    en_clr,
  output logic [NUM_TIMERS-1:0]    tmr_out,
  output logic [NUM_TIMERS-1:0]    tmr_en,
  output logic [NUM_TIMERS-1:0]    tmr_done
);

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    logic w_we;
    // Full 3-bit compare so out-of-range channel numbers hit nothing.
    assign w_we = cfg_we && (cfg_chan == 3'(i));

    vslc_timer_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .DIV_WIDTH     (DIV_WIDTH),
      .RETRIGGER     (RETRIGGER)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cfg_we   (w_we),
      .i_cfg_sel  (cfg_sel),
      .i_cfg_data (cfg_data),
      .i_en_set   (en_set[i]),
      .i_en_clr   (en_clr[i]),
      .o_out      (tmr_out[i]),
      .o_en       (tmr_en[i]),
      .o_done     (tmr_done[i])
    );
  end

endmodule

// File: doc/vslc_timer_bank.md
Name: vslc_timer_bank

Overview:
Parametrised bank of NUM_TIMERS independent programmable timers: the next generation of the single hard-wired VSLC timer. Each channel has its own power-of-two prescaler, two-phase period registers, a mode selector (cycle / one-shot / on-delay), and optional retrigger. The bank sits beside the VSLC fetch/execute core:
- The core writes configuration through a shared register port.
- The core drives per-channel enable set/clear strobes from stack POP/SET/RESET instructions.
- Timer outputs are readable as push sources and drivable to pins.

Parameters:
NUM_TIMERS, 4, number of independent channels (1..8)
COUNTER_WIDTH, 16, width of period registers and phase counters
DIV_WIDTH, 4, width of divisor field; prescaler divides by 2^div, div in 0..2^DIV_WIDTH-1
RETRIGGER, 0, 1 = en_set on a running channel restarts it; 0 = ignored

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  config write strobe, one cycle
cfg_chan  in  3  target channel; values >= NUM_TIMERS ignored
cfg_sel  in  2  0=period_a, 1=period_b, 2=divisor (low DIV_WIDTH bits), 3=mode (low 2 bits)
cfg_data  in  COUNTER_WIDTH  write data
en_set  in  NUM_TIMERS  per-channel enable/start strobe
en_clr  in  NUM_TIMERS  per-channel disable strobe
tmr_out  out  NUM_TIMERS  timer outputs
tmr_en  out  NUM_TIMERS  channel running flags
tmr_done  out  NUM_TIMERS  one-cycle completion pulse

Behaviour:
- Reset is synchronous on rst_n low: reset rst_n, synchronous, active-low; clock clk. Reset values:
  - All outputs 0.
  - Per channel: period_a=1, period_b=2, div=0, mode=CYCLE, phase=A, count=0, prescaler=0.
  - Reset asserted mid-operation aborts the channel immediately; no done pulse is emitted.
- Modes (2 bits):
  - 0 = CYCLE.
  - 1 = ONESHOT.
  - 2 = DELAY (on-delay, PLC TON).
  - 3 = reserved; behaves as CYCLE.
- Disabled channel:
  - tmr_out=0, count=0, prescaler=0, phase=A.
  - Config writes still accepted.
- Start: on the edge where en_set[i]=1 and the channel is idle:
  - tmr_en<=1, phase<=A, count<=0, prescaler<=0.
  - tmr_out<=1 for CYCLE/ONESHOT; tmr_out<=0 for DELAY.
- en_set on a running channel:
  - RETRIGGER=1: restart exactly as Start.
  - RETRIGGER=0: no effect.
- en_clr[i]=1: next edge the channel goes to the disabled state, no done pulse. en_clr wins over a simultaneous en_set.
- Prescaler:
  - While enabled, the prescaler increments every clk.
  - tick = (prescaler == 2^div - 1); on tick the prescaler returns to 0.
  - div=0 gives a tick on every enabled clock.
- Phase counting:
  - On tick: if count >= period of current phase, take the phase transition and set count<=0; otherwise count<=count+1.
  - Compare is >= against live registers, so a period shrunk below the current count ends the phase on the next tick.
  - A phase therefore lasts period+1 ticks. period=0 means 1 tick.
- Phase transitions:
  - CYCLE: A->B sets out=0; B->A sets out=1; repeats forever.
  - ONESHOT: A->B sets out=0; end of B sets tmr_en<=0 and tmr_done=1 for one cycle.
  - DELAY: end of A sets out=1 and tmr_done=1 for one cycle; the channel then holds in B with the count frozen and out=1 until en_clr. period_b is unused.
- Config writes:
  - Take effect on the next edge.
  - Divisor write also clears that channel's prescaler.
  - Mode write while running takes effect at the next phase transition evaluation.
  - Width rule: period registers take cfg_data in full; divisor and mode truncate to their field widths.
- Simultaneous config write and tick on the same channel: the transition uses the old register value; the new value applies from the next tick.
- Counters never wrap: count saturates at its phase transition because of the >= compare.

Decomposition:
- Package vslc_timer_pkg holds:
  - Mode constants: MODE_CYCLE=0, MODE_ONESHOT=1, MODE_DELAY=2.
  - cfg_sel constants: SEL_PERIOD_A, SEL_PERIOD_B, SEL_DIV, SEL_MODE.
  - Reset-default constants for the period registers.
- Sub-module vslc_timer_channel: one channel holding registers, prescaler, counter and FSM (IDLE, PHASE_A, PHASE_B, HOLD).
- Top level: generate loop over NUM_TIMERS plus cfg_chan decode.

Test Plan:
- Reset defaults, CYCLE, div=0, en_set[0] at edge 0: tmr_out[0] is 1 for 2 clocks, then 0 for 3 clocks, with period 5, repeating; tmr_done never asserts.
- ONESHOT ch1, div=2, period_a=3, period_b=1:
  - out high 16 clocks, then low 8 clocks.
  - tmr_done[1] pulses once; tmr_en[1] drops the same edge.
- DELAY ch2, period_a=9, div=0: out stays 0 for 10 clocks, then rises with a done pulse, and stays 1 until en_clr[2]; out falls the next edge.
- en_set and en_clr together on idle ch3: the channel stays disabled. With RETRIGGER=1, en_set mid-phase-B restarts with out=1 and count=0; with RETRIGGER=0 it is ignored.
- Running CYCLE, period_a=100, count at 50, write period_a=10: phase A ends on the next tick. Write to cfg_chan=7 with NUM_TIMERS=4: no channel changes.
- Reset asserted mid-ONESHOT: all outputs 0 next edge, no done pulse; registers return to defaults (period_a=1, period_b=2).
